pc_fetch_unit: RTL

//  Program-counter and fetch sequencer; sits directly downstream of JC_Block.

---
 rtl/pc_fetch_unit_if.sv | 32 +++
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
//   Bundles the redirect, stall and program-memory signals of the fetch unit.
//   Parameter: ADDR_W - address width.
//   Modports:
//     master - the fetch unit: takes jmp_loc/pc_mux_sel/stall/pm_ready,
//              drives pc/fetch_req/current_address/instr_valid/flush
//     slave  - the surrounding logic (JC_Block, decode, program memory)
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] jmp_loc;
    logic              pc_mux_sel;
    logic              stall;
    logic              pm_ready;
    logic [ADDR_W-1:0] pc;
    logic              fetch_req;
    logic [ADDR_W-1:0] current_address;
    logic              instr_valid;
    logic              flush;

    modport master (
        input  jmp_loc, pc_mux_sel, stall, pm_ready,
        output pc, fetch_req, current_address, instr_valid, flush
    );

    modport slave (
        output jmp_loc, pc_mux_sel, stall, pm_ready,
        input  pc, fetch_req, current_address, instr_valid, flush
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Program counter and fetch sequencer sitting downstream of JC_Block.
//   Issues fetch addresses, absorbs memory wait states and decode stalls,
//   and squashes decode for one cycle after each redirect.
//   Parameters: ADDR_W (address width), RESET_VECTOR (PC after reset).
//   Ports:
//     clk            - system clock, rising edge
//     reset          - asynchronous, active-high
//     bus (master)   - jmp_loc, pc_mux_sel, stall, pm_ready in;
//                      pc, fetch_req, current_address, instr_valid, flush out
//     redirect_count - saturating count of redirect edges
//                      (present only when PC_REDIRECT_CNT_EN is defined)
//   Build option: `define PC_REDIRECT_CNT_EN to add redirect_count.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int unsigned          ADDR_W       = 16,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
`ifdef PC_REDIRECT_CNT_EN
    output logic [15:0]       redirect_count,
`endif
    pc_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              flush_q, flush_d;
    logic              redirect;

    // A redirect only counts once out of BOOT; BOOT ignores every input.
    assign redirect = (state_q != BOOT) && bus.pc_mux_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            cur_addr_q    <= RESET_VECTOR;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cur_addr_q    <= cur_addr_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cur_addr_d    = cur_addr_q;
        instr_valid_d = instr_valid_q;
        flush_d       = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            default: begin
                if (bus.pc_mux_sel) begin
                    // Redirect beats stall and memory data; the word returned
                    // for the old pc this cycle is simply dropped.
                    pc_d          = bus.jmp_loc;
                    instr_valid_d = 1'b0;
                    flush_d       = 1'b1;
                    state_d       = FETCH;
                end else if (bus.stall) begin
                    state_d = HOLD;
                end else if (state_q == HOLD) begin
                    // Decode consumed the held instruction in this cycle, so
                    // the slot empties while the same pc is refetched.
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (bus.pm_ready) begin
                    cur_addr_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 1'b1;
                    state_d       = FETCH;
                end else begin
                    instr_valid_d = 1'b0;
                    state_d       = WAIT;
                end
            end
        endcase
    end

    assign bus.pc              = pc_q;
    assign bus.fetch_req       = (state_q == FETCH) || (state_q == WAIT);
    assign bus.current_address = cur_addr_q;
    assign bus.instr_valid     = instr_valid_q;
    assign bus.flush           = flush_q;

`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (redirect && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign redirect_count = cnt_q;
`else
    // No redirect counter in this build; redirect is otherwise unused.
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule
